// File: rtl/ieee754_pkg.sv
// rtl/ieee754_pkg.sv - shared IEEE754 single-precision unpack types and constants
// Imported by the unpack stage, the MAC and the adder pipeline.
package ieee754_pkg;

  localparam int EXP_W    = 10;
  localparam int SIG_W    = 24;
  localparam int EXP_INF  = 255;
  localparam int BIAS     = 127;
  localparam int UNPACK_W = 3 + 1 + EXP_W + SIG_W;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_NORM   = 3'd1,
    CLS_DENORM = 3'd2,
    CLS_INF    = 3'd3,
    CLS_QNAN   = 3'd4,
    CLS_SNAN   = 3'd5
  } ieee754_class_t;

  typedef struct packed {
    ieee754_class_t           cls;
    logic                     sign;
    logic signed [EXP_W-1:0]  exp;
    logic        [SIG_W-1:0]  sig;
  } unpacked_t;

  // dn folds a denormal into ZERO here so later stages only ever see the flushed class.
  function automatic ieee754_class_t classify(input logic [31:0] x, input logic dn);
    logic [7:0]  e;
    logic [22:0] f;
    e = x[30:23];
    f = x[22:0];
    if (e == 8'd0) begin
      classify = ((f == 23'd0) || dn) ? CLS_ZERO : CLS_DENORM;
    end else if (e == 8'hFF) begin
      if (f == 23'd0)  classify = CLS_INF;
      else if (f[22])  classify = CLS_QNAN;
      else             classify = CLS_SNAN;
    end else begin
      classify = CLS_NORM;
    end
  endfunction

endpackage

// File: rtl/ieee754_lzc24.sv
// rtl/ieee754_lzc24.sv - leading-zero count over a 23-bit fraction
// Result is 0..23; 23 means the fraction is all zeros.
module ieee754_lzc24 (
  input  logic [22:0] i_frac,
  output logic [4:0]  o_lzc
);

  // Scanning upward lets the highest set bit win the final assignment.
  always_comb begin
    o_lzc = 5'd23;
    for (int i = 0; i < 23; i++) begin
      if (i_frac[i]) o_lzc = 5'(22 - i);
    end
  end

endmodule

// File: rtl/ieee754_unpack.sv
// rtl/ieee754_unpack.sv - two-stage operand classify/normalize stage feeding the MAC
// S1 captures raw operands, class and LZC; S2 captures normalized significands and exponents.
module ieee754_unpack
  import ieee754_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         src_a,
  input  logic [31:0]         src_b,
  input  logic [31:0]         src_c,
  input  logic                subtract,
  input  logic                dn,
  input  logic [TAG_W-1:0]    tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [UNPACK_W-1:0] out_a,
  output logic [UNPACK_W-1:0] out_b,
  output logic [UNPACK_W-1:0] out_c,
  output logic                out_subtract,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_invalid
);

  logic                w_s1_adv;
  logic                w_s2_adv;
  logic [31:0]         w_src [3];
  logic [4:0]          w_lzc [3];
  unpacked_t           w_unp [3];
  logic                w_invalid;

  logic                r_s1_valid;
  logic [31:0]         r_s1_src [3];
  ieee754_class_t      r_s1_cls [3];
  logic [4:0]          r_s1_lzc [3];
  logic                r_s1_subtract;
  logic [TAG_W-1:0]    r_s1_tag;

  logic                r_s2_valid;
  unpacked_t           r_out [3];
  logic                r_out_subtract;
  logic [TAG_W-1:0]    r_out_tag;
  logic                r_out_invalid;

  // in_ready is combinational from out_ready through the advance chain.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  assign w_src[0] = src_a;
  assign w_src[1] = src_b;
  assign w_src[2] = src_c;

  for (genvar g = 0; g < 3; g++) begin : g_lzc
    ieee754_lzc24 u_lzc (
      .i_frac (w_src[g][22:0]),
      .o_lzc  (w_lzc[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_subtract <= 1'b0;
      r_s1_tag      <= '0;
      for (int i = 0; i < 3; i++) begin
        r_s1_src[i] <= '0;
        r_s1_cls[i] <= CLS_ZERO;
        r_s1_lzc[i] <= '0;
      end
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_subtract <= subtract;
        r_s1_tag      <= tag;
        for (int i = 0; i < 3; i++) begin
          r_s1_src[i] <= w_src[i];
          r_s1_cls[i] <= classify(w_src[i], dn);
          r_s1_lzc[i] <= w_lzc[i];
        end
      end
    end
  end

  // Denormal shift is lzc+1 (1..23) so the top fraction one lands on bit 23; exp = -lzc.
  function automatic unpacked_t unpack_op(input logic [31:0] x, input ieee754_class_t cls,
                                          input logic [4:0] lzc);
    unpacked_t  u;
    logic [4:0] sh;
    u.cls  = cls;
    u.sign = x[31];
    u.exp  = '0;
    u.sig  = '0;
    sh     = lzc + 5'd1;
    case (cls)
      CLS_NORM: begin
        u.exp = {2'b00, x[30:23]};
        u.sig = {1'b1, x[22:0]};
      end
      CLS_DENORM: begin
        u.exp = -$signed({5'd0, lzc});
        u.sig = {1'b0, x[22:0]} << sh;
      end
      CLS_INF: begin
        u.exp = EXP_W'(EXP_INF);
        u.sig = {1'b1, 23'd0};
      end
      CLS_QNAN, CLS_SNAN: begin
        u.exp = EXP_W'(EXP_INF);
        u.sig = {1'b1, x[22:0]};
      end
      default: ;
    endcase
    return u;
  endfunction

  always_comb begin
    w_invalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_unp[i]  = unpack_op(r_s1_src[i], r_s1_cls[i], r_s1_lzc[i]);
      w_invalid = w_invalid | (r_s1_cls[i] == CLS_SNAN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid     <= 1'b0;
      r_out_subtract <= 1'b0;
      r_out_tag      <= '0;
      r_out_invalid  <= 1'b0;
      for (int i = 0; i < 3; i++) r_out[i] <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_subtract <= r_s1_subtract;
        r_out_tag      <= r_s1_tag;
        r_out_invalid  <= w_invalid;
        for (int i = 0; i < 3; i++) r_out[i] <= w_unp[i];
      end
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_a        = r_out[0];
  assign out_b        = r_out[1];
  assign out_c        = r_out[2];
  assign out_subtract = r_out_subtract;
  assign out_tag      = r_out_tag;
  assign out_invalid  = r_out_invalid;

endmodule

// File: tb/tb_ieee754_unpack.sv
// tb/tb_ieee754_unpack.sv - scoreboard bench for ieee754_unpack
// Expected operand sets are queued on acceptance and compared while out_valid is high.
module tb_ieee754_unpack;

  typedef struct packed {
    logic [37:0] a;
    logic [37:0] b;
    logic [37:0] c;
    logic        sub;
    logic [3:0]  tag;
    logic        inv;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src_a, src_b, src_c;
  logic        subtract;
  logic        dn;
  logic [3:0]  tag;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] out_a, out_b, out_c;
  logic        out_subtract;
  logic [3:0]  out_tag;
  logic        out_invalid;

  rec_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  ieee754_unpack #(.TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .src_a        (src_a),
    .src_b        (src_b),
    .src_c        (src_c),
    .subtract     (subtract),
    .dn           (dn),
    .tag          (tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_c        (out_c),
    .out_subtract (out_subtract),
    .out_tag      (out_tag),
    .out_invalid  (out_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference: denormals are normalized by repeated left shift rather than a count.
  function automatic logic [37:0] model(input logic [31:0] x, input logic dnf);
    logic [7:0]  e;
    logic [22:0] f;
    logic [23:0] sig;
    int          cnt;
    e = x[30:23];
    f = x[22:0];
    if (e == 8'd0) begin
      if (f == 23'd0 || dnf) return {3'd0, x[31], 10'd0, 24'd0};
      sig = {1'b0, f};
      cnt = 0;
      while (!sig[23]) begin
        sig = sig << 1;
        cnt++;
      end
      return {3'd2, x[31], 10'(1 - cnt), sig};
    end
    if (e == 8'hFF) begin
      if (f == 23'd0) return {3'd3, x[31], 10'd255, 24'h800000};
      return {(f[22] ? 3'd4 : 3'd5), x[31], 10'd255, 1'b1, f};
    end
    return {3'd1, x[31], 2'b00, e, 1'b1, f};
  endfunction

  function automatic rec_t mk(input logic [31:0] a, b, c, input logic sub, dnf,
                              input logic [3:0] t);
    rec_t r;
    r.a   = model(a, dnf);
    r.b   = model(b, dnf);
    r.c   = model(c, dnf);
    r.sub = sub;
    r.tag = t;
    r.inv = (r.a[37:35] == 3'd5) || (r.b[37:35] == 3'd5) || (r.c[37:35] == 3'd5);
    return r;
  endfunction

  task automatic drive(input logic [31:0] a, b, c, input logic sub, d, input logic [3:0] t);
    src_a    = a;
    src_b    = b;
    src_c    = c;
    subtract = sub;
    dn       = d;
    tag      = t;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, b, c, input logic sub, d, input logic [3:0] t,
                      input rec_t e);
    drive(a, b, c, sub, d, t);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("send_timeout", 1'b1, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 1'b0);
      end else begin
        chk("out_set", {out_a, out_b, out_c, out_subtract, out_tag, out_invalid}, sb[0]);
        if (out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb, rc;
    int          base;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src_a = '0; src_b = '0; src_c = '0; subtract = 1'b0; dn = 1'b0; tag = '0;

    @(posedge clk); #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_invalid", out_invalid, 1'b0);
    chk("reset_out_data", {out_a, out_b, out_c, out_tag}, '0);
    rst_n = 1'b1;
    chk("in_ready_after_reset", in_ready, 1'b1);

    // Normals, then latency: nothing after the accept edge, valid after the next edge.
    send(32'h3F800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 4'd1,
         '{a: {3'd1, 1'b0, 10'd127, 24'h800000}, b: {3'd1, 1'b0, 10'd128, 24'h800000},
           c: '0, sub: 1'b0, tag: 4'd1, inv: 1'b0});
    chk("latency_after_accept_edge", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("latency_after_second_edge", out_valid, 1'b1);
    drain();

    // Back-to-back: denormals, flush with specials, then dn dropped for the next set.
    send(32'h00000001, 32'h00400000, 32'h3F800000, 1'b1, 1'b0, 4'd2,
         '{a: {3'd2, 1'b0, 10'h3EA, 24'h800000}, b: {3'd2, 1'b0, 10'd0, 24'h800000},
           c: {3'd1, 1'b0, 10'd127, 24'h800000}, sub: 1'b1, tag: 4'd2, inv: 1'b0});
    send(32'h80000001, 32'h7F800000, 32'h7FA00000, 1'b0, 1'b1, 4'd3,
         '{a: {3'd0, 1'b1, 10'd0, 24'd0}, b: {3'd3, 1'b0, 10'd255, 24'h800000},
           c: {3'd5, 1'b0, 10'd255, 24'hA00000}, sub: 1'b0, tag: 4'd3, inv: 1'b1});
    send(32'h80000001, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 4'd4,
         '{a: {3'd2, 1'b1, 10'h3EA, 24'h800000}, b: {3'd4, 1'b0, 10'd255, 24'hC00000},
           c: {3'd1, 1'b0, 10'd127, 24'h800000}, sub: 1'b0, tag: 4'd4, inv: 1'b0});
    drain();

    // Backpressure: 6 sets, out_ready low for 4 edges.
    base = n_out;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      if (i == 1) ra[30:23] = 8'd0;
      if (i == 2) rb[30:23] = 8'hFF;
      if (i == 2) begin
        drive(ra, rb, rc, i[0], 1'b0, 4'(i));
        repeat (2) begin
          @(posedge clk); #1;
          chk("stall_in_ready_low", in_ready, 1'b0);
        end
        out_ready = 1'b1;
      end
      send(ra, rb, rc, i[0], 1'b0, 4'(i), mk(ra, rb, rc, i[0], 1'b0, 4'(i)));
      if (i == 1) chk("in_ready_after_two", in_ready, 1'b0);
    end
    drain();
    chk("stream_count", n_out - base, 6);

    // Bubble collapse: S2 occupied and stalled, S1 empty, new set still accepted.
    out_ready = 1'b0;
    send(32'h3F800000, 32'h00000010, 32'h7F800000, 1'b0, 1'b0, 4'd6,
         mk(32'h3F800000, 32'h00000010, 32'h7F800000, 1'b0, 1'b0, 4'd6));
    @(posedge clk); #1;
    chk("bubble_out_valid", out_valid, 1'b1);
    chk("bubble_in_ready", in_ready, 1'b1);
    send(32'hC0490FDB, 32'h00000000, 32'h7FBFFFFF, 1'b1, 1'b0, 4'd7,
         mk(32'hC0490FDB, 32'h00000000, 32'h7FBFFFFF, 1'b1, 1'b0, 4'd7));
    chk("bubble_waits_in_s1", in_ready, 1'b0);
    out_ready = 1'b1;
    drain();

    // Reset with two sets in flight.
    out_ready = 1'b0;
    send(32'h40400000, 32'h00000003, 32'h0, 1'b0, 1'b0, 4'd8,
         mk(32'h40400000, 32'h00000003, 32'h0, 1'b0, 1'b0, 4'd8));
    send(32'h41000000, 32'h7FC00001, 32'h0, 1'b0, 1'b0, 4'd9,
         mk(32'h41000000, 32'h7FC00001, 32'h0, 1'b0, 1'b0, 4'd9));
    #1 rst_n = 1'b0;
    #1 chk("reset_drops_out_valid", out_valid, 1'b0);
    sb.delete();
    out_ready = 1'b1;
    #20 rst_n = 1'b1;
    chk("in_ready_post_midreset", in_ready, 1'b1);
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_set", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    send(32'h00000100, 32'h3F800000, 32'h80000000, 1'b1, 1'b0, 4'd10,
         mk(32'h00000100, 32'h3F800000, 32'h80000000, 1'b1, 1'b0, 4'd10));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ieee754_unpack.md
# ieee754_unpack

Operand unpack stage directly upstream of the FPU multiply-accumulate pipeline. It accepts three raw single-precision operands (a, b, c) plus control, then classifies each operand and normalizes denormals so that every finite non-zero significand carries an explicit leading one at bit 23. It also optionally flushes denormals to zero per FPSCR.DN. Results leave through a two-stage valid/ready pipeline, so the MAC datapath never sees a denormal.

## Interface
Parameters:
- TAG_W, 4: width of the pass-through instruction/destination tag.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  stage can accept this cycle.
- src_a, src_b, src_c  input  32 each  raw IEEE754 single operands.
- subtract  input  1  accumulate-subtract control, passed through.
- dn  input  1  FPSCR.DN; 1 = flush denormal inputs to signed zero.
- tag  input  TAG_W  passed through unchanged.
- out_valid  output  1  unpacked operand set available.
- out_ready  input  1  downstream accepts.
- out_a, out_b, out_c  output  38 each  unpacked operand {class[2:0], sign, exp[9:0] signed, sig[23:0]}.
- out_subtract  output  1  registered copy of subtract.
- out_tag  output  TAG_W  registered copy of tag.
- out_invalid  output  1  any operand is a signalling NaN.

## Operation
- Class encoding (3 bits): ZERO=0, NORM=1, DENORM=2, INF=3, QNAN=4, SNAN=5.
- Field rules per operand, with e = bits[30:23] and f = bits[22:0]:
  - e=0, f=0: ZERO; exp=0, sig=0.
  - e=0, f≠0, dn=0: DENORM. Let p = index of the top one in f. Then sig = f << (23−p), giving bit 23 = 1, and exp = p−22 (range −22..0).
  - e=0, f≠0, dn=1: ZERO; sign preserved; exp=0, sig=0.
  - 1≤e≤254: NORM; exp=e, sig={1,f}.
  - e=255, f=0: INF; exp=255, sig=0x800000.
  - e=255, f≠0: QNAN if f[22]=1, else SNAN; exp=255, sig={1,f}.
- Sign is always bit 31, including for flushed zeros.
- Exponents are biased, so the MAC exponent sum stays exp_a+exp_b−127 in 10-bit signed arithmetic.
- out_invalid = OR over the three operands of (class==SNAN).
- Stage 1 (S1): registers the raw inputs plus the per-operand class and the 5-bit leading-zero count of f.
- Stage 2 (S2): registers the shifted significands, computed exponents and out_invalid. Shift amount is 0..23.

## Timing
- Latency: 2 cycles from the in_valid&&in_ready edge to out_valid, when there is no stall.
- Throughput: 1 operand set per cycle while out_ready=1.
- Handshake:
  - A transfer occurs on posedge when valid&&ready.
  - out_* are stable while out_valid=1 and out_ready=0.
  - in_valid must not depend on in_ready.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready; this is accepted and documented.
- Bubbles collapse: an empty S2 accepts from S1 even while out_ready=0.
- Simultaneous events: output transfer and input acceptance in the same cycle is legal; the pipeline shifts by one.
- Reset values:
  - s1_valid = s2_valid = 0, out_valid = 0, out_invalid = 0.
  - All data registers 0.
  - in_ready = 1 once rst_n is deasserted.
- Reset mid-operation: in-flight sets are discarded and not replayed; out_valid drops asynchronously.
- dn is sampled with the operands in S1; a later change of dn does not affect in-flight sets.

## Structure
- Package ieee754_pkg:
  - class enum ieee754_class_t;
  - packed struct unpacked_t {class, sign, exp, sig};
  - constants EXP_W=10, SIG_W=24, EXP_INF=255, BIAS=127.
  - The MAC and the future adder pipeline import the same package.
- Sub-module ieee754_lzc24: purely combinational leading-zero count over 23 bits (output 0..23); instanced three times in S1.
- ieee754_unpack holds the pipeline registers, the handshake and the three shifters.

## Test plan
- Normals, no stall: a=0x3F800000, b=0x40000000, c=0x00000000.
  - out_a = NORM, exp=127, sig=0x800000; out_b exp=128; out_c = ZERO.
  - out_valid rises exactly 2 cycles after acceptance.
- Denormal, dn=0: a=0x00000001 → DENORM, exp=−22, sig=0x800000. a=0x00400000 → exp=0, sig=0x800000.
- Flush, dn=1: a=0x80000001 → ZERO, sign=1, exp=0, sig=0. Specials: b=0x7F800000 → INF; c=0x7FA00000 → SNAN with out_invalid=1; c=0x7FC00000 → QNAN with out_invalid=0.
- Backpressure:
  - Stream 6 sets with out_ready held 0 for 4 cycles; in_ready drops after 2 sets are accepted.
  - After release, all 6 sets emerge in order with tags 0..5, none dropped or duplicated, and out_* are stable during the stall.
- Bubble collapse: 1 set in S2 with out_ready=0 and S1 empty; new input is accepted (in_ready=1) and waits in S1.
- Reset: assert rst_n=0 with 2 sets in flight; out_valid=0 immediately. After release, in_ready=1 and no stale set appears.
